// File: rtl/multi_bank_result_ctrl_if.sv
// Bus bundle between the core/system requesters, the result SRAM banks and
// the multi-bank result controller.
interface multi_bank_result_ctrl_if #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = $clog2(NUM_BANKS);

  logic                            sel;
  logic                            core_req;
  logic                            core_wen;
  logic [ADDR_WIDTH-1:0]           core_addr;
  logic                            sys_req;
  logic                            sys_wen;
  logic [ADDR_WIDTH-1:0]           sys_addr;
  logic                            burst_start;
  logic [ADDR_WIDTH-1:0]           burst_addr;
  logic [ADDR_WIDTH:0]             burst_len;
  logic                            burst_busy;
  logic                            burst_done;
  logic [NUM_BANKS-1:0]            cen;
  logic                            wen;
  logic [ADDR_WIDTH-BW-1:0]        bank_addr;
  logic [NUM_BANKS*DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0]           rd_data;
  logic                            rd_valid;
  logic                            rd_src;

  modport slave (
    input  sel, core_req, core_wen, core_addr, sys_req, sys_wen, sys_addr,
           burst_start, burst_addr, burst_len, q,
    output burst_busy, burst_done, cen, wen, bank_addr, rd_data, rd_valid, rd_src
  );

  modport master (
    output sel, core_req, core_wen, core_addr, sys_req, sys_wen, sys_addr,
           burst_start, burst_addr, burst_len, q,
    input  burst_busy, burst_done, cen, wen, bank_addr, rd_data, rd_valid, rd_src
  );
endinterface

// File: rtl/multi_bank_result_ctrl.sv
// N-bank result SRAM controller: flat-address decode, latency-tracked read
// return mux and a pre-emptible system burst-read engine.
module multi_bank_result_ctrl #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input logic                clk,
  input logic                rst_n,
  multi_bank_result_ctrl_if.slave bus
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int LW = ADDR_WIDTH - BW;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t                          state;
  logic [ADDR_WIDTH-1:0]           ptr;
  logic [ADDR_WIDTH:0]             remaining;
  logic                            busy_q, done_q;

  logic                            acc_en, acc_wen, acc_src, burst_issue, rd_issue, pend;
  logic [ADDR_WIDTH-1:0]           acc_addr;
  logic [BW-1:0]                   bank_sel;

  logic [RD_LATENCY:1]             vld_pipe, src_pipe;
  logic [RD_LATENCY:1][BW-1:0]     bank_pipe;
  logic [DATA_WIDTH-1:0]           rd_word, rd_hold;

  // Core wins whenever sel=1; an active burst silently drops sys_req.
  always_comb begin
    acc_en      = 1'b0;
    acc_wen     = 1'b0;
    acc_src     = 1'b0;
    acc_addr    = '0;
    burst_issue = 1'b0;
    if (bus.sel) begin
      acc_en   = bus.core_req;
      acc_wen  = bus.core_wen;
      acc_addr = bus.core_addr;
    end else if (state == BURST) begin
      acc_en      = 1'b1;
      acc_src     = 1'b1;
      acc_addr    = ptr;
      burst_issue = 1'b1;
    end else begin
      acc_en   = bus.sys_req;
      acc_wen  = bus.sys_wen;
      acc_src  = 1'b1;
      acc_addr = bus.sys_addr;
    end
  end

  assign bank_sel      = acc_addr[ADDR_WIDTH-1 -: BW];
  assign rd_issue      = acc_en & ~acc_wen;
  assign bus.cen       = acc_en ? (NUM_BANKS'(1) << bank_sel) : '0;
  assign bus.wen       = acc_en & acc_wen;
  assign bus.bank_addr = acc_en ? acc_addr[LW-1:0] : '0;

  // System read still in flight that will not reach the output next cycle;
  // lets burst_done line up with the final burst rd_valid.
  always_comb begin
    pend = 1'b0;
    if (RD_LATENCY > 1) pend = rd_issue & acc_src;
    for (int k = 1; k < RD_LATENCY - 1; k++) pend = pend | src_pipe[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      src_pipe  <= '0;
      bank_pipe <= '0;
      rd_hold   <= '0;
    end else begin
      vld_pipe[1]  <= rd_issue;
      src_pipe[1]  <= rd_issue & acc_src;
      bank_pipe[1] <= bank_sel;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        src_pipe[k]  <= src_pipe[k-1];
        bank_pipe[k] <= bank_pipe[k-1];
      end
      if (vld_pipe[RD_LATENCY]) rd_hold <= rd_word;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (bank_pipe[RD_LATENCY] == BW'(i)) rd_word = bus.q[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign bus.rd_valid = vld_pipe[RD_LATENCY];
  assign bus.rd_src   = src_pipe[RD_LATENCY];
  assign bus.rd_data  = vld_pipe[RD_LATENCY] ? rd_word : rd_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.burst_start) begin
          if (bus.burst_len == '0) begin
            done_q <= 1'b1;
          end else begin
            state     <= BURST;
            busy_q    <= 1'b1;
            ptr       <= bus.burst_addr;
            remaining <= bus.burst_len;
          end
        end
        BURST: if (burst_issue) begin
          ptr       <= ptr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == (ADDR_WIDTH+1)'(1)) begin
            state  <= DRAIN;
            done_q <= ~pend;
          end
        end
        DRAIN: begin
          // done is raised in the final DRAIN cycle, then we fall back to IDLE
          if (done_q) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            done_q <= ~pend;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.burst_busy = busy_q;
  assign bus.burst_done = done_q;
endmodule

// File: tb/tb_multi_bank_result_ctrl.sv
// Bench for multi_bank_result_ctrl: two instances (read latency 1 and 3) share
// stimulus; a cycle-level behavioural model checks both every cycle.
module tb_multi_bank_result_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel = 0, core_req = 0, core_wen = 0, sys_req = 0, sys_wen = 0, burst_start = 0;
  logic [13:0] core_addr = 0, sys_addr = 0, burst_addr = 0;
  logic [14:0] burst_len = 0;
  logic [127:0] qbus;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] qv(input int b, input int c);
    logic [31:0] c32, b32;
    c32 = c;
    b32 = b;
    return {8'hA5, c32[19:0], b32[3:0]};
  endfunction

  always_comb
    for (int i = 0; i < 4; i++) qbus[i*32 +: 32] = qv(i, cyc);

  multi_bank_result_ctrl_if #(.NUM_BANKS(4), .ADDR_WIDTH(14), .DATA_WIDTH(32)) if0 ();
  multi_bank_result_ctrl_if #(.NUM_BANKS(4), .ADDR_WIDTH(14), .DATA_WIDTH(32)) if1 ();

  assign if0.sel = sel;             assign if1.sel = sel;
  assign if0.core_req = core_req;   assign if1.core_req = core_req;
  assign if0.core_wen = core_wen;   assign if1.core_wen = core_wen;
  assign if0.core_addr = core_addr; assign if1.core_addr = core_addr;
  assign if0.sys_req = sys_req;     assign if1.sys_req = sys_req;
  assign if0.sys_wen = sys_wen;     assign if1.sys_wen = sys_wen;
  assign if0.sys_addr = sys_addr;   assign if1.sys_addr = sys_addr;
  assign if0.burst_start = burst_start; assign if1.burst_start = burst_start;
  assign if0.burst_addr = burst_addr;   assign if1.burst_addr = burst_addr;
  assign if0.burst_len = burst_len;     assign if1.burst_len = burst_len;
  assign if0.q = qbus;              assign if1.q = qbus;

  multi_bank_result_ctrl #(.NUM_BANKS(4), .ADDR_WIDTH(14), .DATA_WIDTH(32), .RD_LATENCY(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  multi_bank_result_ctrl #(.NUM_BANKS(4), .ADDR_WIDTH(14), .DATA_WIDTH(32), .RD_LATENCY(3))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [3:0]  o_cen[2];
  logic [11:0] o_ba[2];
  logic [31:0] o_rd[2];
  logic        o_wen[2], o_rv[2], o_rs[2], o_busy[2], o_done[2];
  assign o_cen[0] = if0.cen;        assign o_cen[1] = if1.cen;
  assign o_ba[0] = if0.bank_addr;   assign o_ba[1] = if1.bank_addr;
  assign o_rd[0] = if0.rd_data;     assign o_rd[1] = if1.rd_data;
  assign o_wen[0] = if0.wen;        assign o_wen[1] = if1.wen;
  assign o_rv[0] = if0.rd_valid;    assign o_rv[1] = if1.rd_valid;
  assign o_rs[0] = if0.rd_src;      assign o_rs[1] = if1.rd_src;
  assign o_busy[0] = if0.burst_busy; assign o_busy[1] = if1.burst_busy;
  assign o_done[0] = if0.burst_done; assign o_done[1] = if1.burst_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: per requester rules, a burst cursor, and a calendar of expected read returns.
  int          lat[2] = '{1, 3};
  bit          m_burst[2];
  logic [13:0] m_ptr[2];
  int          m_left[2];
  int          busy_until[2] = '{-1, -1};
  int          done_at[2] = '{-1, -1};
  logic [31:0] m_hold[2];
  bit          ev[2][1024];
  int          eb[2][1024];
  bit          es[2][1024];

  always @(negedge clk) begin
    logic        acc, w, src, ebusy;
    logic [13:0] a;
    logic [3:0]  ecen;
    int          idx;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_burst[d] = 0; busy_until[d] = -1; done_at[d] = -1; m_hold[d] = 0;
        for (int k = 0; k < 8; k++) ev[d][(cyc + k) % 1024] = 0;
        check($sformatf("rst_cen%0d", d), o_cen[d], 0);
        check($sformatf("rst_busy%0d", d), o_busy[d], 0);
        check($sformatf("rst_done%0d", d), o_done[d], 0);
        check($sformatf("rst_rv%0d", d), o_rv[d], 0);
        check($sformatf("rst_rd%0d", d), o_rd[d], 0);
      end else begin
        if (sel) begin
          acc = core_req; w = core_wen; a = core_addr; src = 0;
        end else if (m_burst[d]) begin
          acc = 1; w = 0; a = m_ptr[d]; src = 1;
        end else begin
          acc = sys_req; w = sys_wen; a = sys_addr; src = 1;
        end
        ecen = acc ? (4'b0001 << a[13:12]) : 4'b0000;
        check($sformatf("cen%0d", d), o_cen[d], ecen);
        check($sformatf("wen%0d", d), o_wen[d], acc & w);
        if (acc) check($sformatf("bank_addr%0d", d), o_ba[d], a[11:0]);
        idx = cyc % 1024;
        check($sformatf("rd_valid%0d", d), o_rv[d], ev[d][idx]);
        if (ev[d][idx]) begin
          m_hold[d] = qv(eb[d][idx], cyc);
          check($sformatf("rd_src%0d", d), o_rs[d], es[d][idx]);
        end
        check($sformatf("rd_data%0d", d), o_rd[d], m_hold[d]);
        ebusy = m_burst[d] || (cyc <= busy_until[d]);
        check($sformatf("busy%0d", d), o_busy[d], ebusy);
        check($sformatf("done%0d", d), o_done[d], cyc == done_at[d]);
        ev[d][idx] = 0;
        if (acc && !w) begin
          ev[d][(cyc + lat[d]) % 1024] = 1;
          eb[d][(cyc + lat[d]) % 1024] = int'(a[13:12]);
          es[d][(cyc + lat[d]) % 1024] = src;
        end
        if (!sel && m_burst[d]) begin
          m_ptr[d] = m_ptr[d] + 14'd1;
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_burst[d] = 0;
            busy_until[d] = cyc + lat[d];
            done_at[d] = cyc + lat[d];
          end
        end
        if (!ebusy && burst_start) begin
          if (burst_len == 0) done_at[d] = cyc + 1;
          else begin
            m_burst[d] = 1; m_ptr[d] = burst_addr; m_left[d] = int'(burst_len);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  exp2_cen[4] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010};
  logic [11:0] exp2_ba[4]  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

  initial begin
    int cnt, dn;
    #1 rst_n = 0;
    tick(); tick();
    @(negedge clk);
    check("lit_rst_busy", if0.burst_busy, 0);
    check("lit_rst_rv", if0.rd_valid, 0);
    check("lit_rst_rd", if0.rd_data, 0);
    tick();
    rst_n = 1;
    tick();

    // core read, decode and return mux
    sel = 1; core_req = 1; core_wen = 0; core_addr = 14'h2005;
    @(negedge clk);
    check("t1_cen", if0.cen, 4'b0100);
    check("t1_bank_addr", if0.bank_addr, 12'h005);
    tick();
    core_req = 0;
    @(negedge clk);
    check("t1_rv", if0.rd_valid, 1);
    check("t1_src", if0.rd_src, 0);
    check("t1_data", if0.rd_data, {8'hA5, cyc[19:0], 4'h2});
    tick();
    core_req = 1; core_wen = 1; core_addr = 14'h3000;
    @(negedge clk);
    check("t1_wcen", if0.cen, 4'b1000);
    check("t1_wen", if0.wen, 1);
    tick();
    core_req = 0;
    @(negedge clk);
    check("t1_wr_no_rv", if0.rd_valid, 0);
    tick();
    sel = 0; sys_req = 1; sys_wen = 0; sys_addr = 14'h1234;
    tick();
    sys_wen = 1; sys_addr = 14'h0ABC;
    tick();
    sys_req = 0;
    repeat (4) tick();

    // burst across a bank edge, sys_req and a second start ignored
    burst_start = 1; burst_addr = 14'h0FFE; burst_len = 15'd4;
    tick();
    burst_start = 0; sys_req = 1; sys_wen = 1; sys_addr = 14'h3ABC;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin burst_start = 1; burst_addr = 14'h0200; burst_len = 15'd5; end
      else burst_start = 0;
      @(negedge clk);
      if (i < 4) begin
        check("t2_cen", if0.cen, exp2_cen[i]);
        check("t2_bank_addr", if0.bank_addr, exp2_ba[i]);
      end
      if (if0.rd_valid && if0.rd_src) cnt++;
      check("t2_done", if0.burst_done, i == 4);
      tick();
    end
    check("t2_words", cnt, 4);
    sys_req = 0;
    repeat (6) tick();

    // suspend/resume around a core write
    burst_start = 1; burst_addr = 14'h0FFE; burst_len = 15'd4;
    tick();
    burst_start = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin sel = 1; core_req = 1; core_wen = 1; core_addr = 14'h3000; end
      if (i == 5) begin sel = 0; core_req = 0; core_wen = 0; end
      @(negedge clk);
      if (i >= 2 && i <= 4) begin
        check("t3_core_cen", if0.cen, 4'b1000);
        check("t3_core_wen", if0.wen, 1);
      end
      if (i == 5) begin
        check("t3_resume_cen", if0.cen, 4'b0010);
        check("t3_resume_ba", if0.bank_addr, 12'h000);
      end
      if (if0.rd_valid && if0.rd_src) cnt++;
      tick();
    end
    check("t3_words", cnt, 4);
    repeat (2) tick();

    // address wrap with latency 3 (instance u1)
    burst_start = 1; burst_addr = 14'h3FFF; burst_len = 15'd2;
    tick();
    burst_start = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("t4_cen0", if1.cen, 4'b1000);
        check("t4_ba0", if1.bank_addr, 12'hFFF);
      end
      if (i == 1) begin
        check("t4_cen1", if1.cen, 4'b0001);
        check("t4_ba1", if1.bank_addr, 12'h000);
      end
      check("t4_rv", if1.rd_valid, (i == 3) || (i == 4));
      check("t4_done", if1.burst_done, i == 4);
      tick();
    end
    repeat (3) tick();

    // zero-length burst
    burst_start = 1; burst_addr = 14'h1111; burst_len = 15'd0;
    @(negedge clk);
    check("t5_cen_start", if0.cen, 0);
    tick();
    burst_start = 0;
    @(negedge clk);
    check("t5_done0", if0.burst_done, 1);
    check("t5_done1", if1.burst_done, 1);
    check("t5_cen", if0.cen, 0);
    check("t5_busy", if0.burst_busy, 0);
    tick();
    @(negedge clk);
    check("t5_done_once", if0.burst_done, 0);
    tick();

    // reset in the middle of a burst, then a clean burst
    burst_start = 1; burst_addr = 14'h0100; burst_len = 15'd8;
    tick();
    burst_start = 0;
    tick(); tick();
    #1 rst_n = 0;
    #1;
    check("t6_cen", if0.cen, 0);
    check("t6_busy0", if0.burst_busy, 0);
    check("t6_busy1", if1.burst_busy, 0);
    check("t6_rv0", if0.rd_valid, 0);
    check("t6_rv1", if1.rd_valid, 0);
    check("t6_rd0", if0.rd_data, 0);
    check("t6_rd1", if1.rd_data, 0);
    tick();
    rst_n = 1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if0.burst_done || if1.burst_done) dn++;
      tick();
    end
    check("t6_no_done", dn, 0);
    burst_start = 1; burst_addr = 14'h0100; burst_len = 15'd3;
    tick();
    burst_start = 0;
    cnt = 0; dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if0.rd_valid && if0.rd_src) cnt++;
      if (if0.burst_done) dn++;
      tick();
    end
    check("t6_words", cnt, 3);
    check("t6_done_cnt", dn, 1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
